// File: rtl/instr_fetch_unit_pkg.sv
// Shared processor definitions for the IF stage: datapath widths, reset PC
// and the fetch-queue entry layout.
package instr_fetch_unit_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at grant, filled at response
// and popped by decode. Pointers carry an extra MSB so full != empty.
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_instr,
  input  logic              pop,
  input  logic              clear,
  output logic [PW-1:0]     count,
  output logic [PW-1:0]     in_flight,
  output fq_entry_t         head
);

  fq_entry_t       entries [DEPTH];
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   rd_ptr;

  // NOTE: the whole array is reset (not just the filled bits) so the
  // decode-facing pc/instr read 0 out of reset; cheap at this depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '{pc: RESET_PC, instr: '0, filled: 1'b0};
      end
    end else if (clear) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].filled <= 1'b0;
      end
    end else begin
      // Alloc, fill and pop always target distinct slots under the protocol.
      if (alloc) begin
        entries[alloc_ptr[PW-2:0]].pc     <= alloc_pc;
        entries[alloc_ptr[PW-2:0]].filled <= 1'b0;
        alloc_ptr                         <= alloc_ptr + 1'b1;
      end
      if (fill) begin
        entries[fill_ptr[PW-2:0]].instr  <= fill_instr;
        entries[fill_ptr[PW-2:0]].filled <= 1'b1;
        fill_ptr                         <= fill_ptr + 1'b1;
      end
      if (pop) begin
        entries[rd_ptr[PW-2:0]].filled <= 1'b0;
        rd_ptr                         <= rd_ptr + 1'b1;
      end
    end
  end

  assign count     = alloc_ptr - rd_ptr;
  assign in_flight = alloc_ptr - fill_ptr;
  assign head      = entries[rd_ptr[PW-2:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF-stage fetch engine: issues in-order imem requests for currentPC,
// buffers responses and hands them to decode; drops stale data on redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] currentPC,
  output logic              PCWrite,
  input  logic              redirect,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] count;
  logic [PW-1:0] in_flight;
  logic [PW-1:0] drop_cnt;
  logic [PW:0]   occupancy;
  fq_entry_t     head;
  logic          grant;
  logic          fill;
  logic          pop;

  // Stale responses still owed by memory occupy slots, so they count
  // against the issue budget just like buffered entries.
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt};
  assign imem_req  = !rst && !redirect && (occupancy < (PW + 1)'(DEPTH));
  assign imem_addr = currentPC;
  assign grant     = imem_req && imem_gnt;
  assign PCWrite   = grant || redirect;

  assign fill     = imem_rvalid && (drop_cnt == '0) && !redirect;
  assign if_valid = !rst && !redirect && head.filled && (count != '0);
  assign pop      = if_valid && id_ready;
  assign if_instr = head.instr;
  assign if_pc    = head.pc;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side here sees the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= drop_cnt + in_flight - {{(PW-1){1'b0}}, imem_rvalid};
    end else if (imem_rvalid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .alloc      (grant),
    .alloc_pc   (currentPC),
    .fill       (fill),
    .fill_instr (imem_rdata),
    .pop        (pop),
    .clear      (redirect),
    .count      (count),
    .in_flight  (in_flight),
    .head       (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and an in-order memory,
// scoreboards delivered instructions and runs directed timing scenarios.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] currentPC;
  logic        PCWrite;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  instr_fetch_unit #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .currentPC   (currentPC),
    .PCWrite     (PCWrite),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .id_ready    (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } mem_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mem_t mem_q [$];
  exp_t exp_q [$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int grants   = 0;
  int lat      = 1;

  logic        gnt_en, rdy_en, redir_en;
  logic [31:0] redir_target, pc_next;
  logic        s_req, s_pcw, s_valid;
  logic [31:0] s_pc, s_addr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h0013_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock cycle: PC register, memory and control driven at negedge,
  // DUT outputs sampled 1 ns later.
  task automatic step();
    @(negedge clk);
    cyc++;
    currentPC = pc_next;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    imem_gnt = gnt_en;
    id_ready = rdy_en;
    redirect = redir_en;
    #1;
    s_req   = imem_req;
    s_pcw   = PCWrite;
    s_valid = if_valid;
    s_pc    = if_pc;
    s_addr  = imem_addr;
    if (redirect) exp_q.delete();
    if (imem_req && imem_gnt) begin
      mem_q.push_back('{cyc + lat, imem_addr});
      exp_q.push_back('{imem_addr, instr_of(imem_addr)});
      grants++;
    end
    pc_next = redirect ? redir_target : (PCWrite ? currentPC + 32'd4 : currentPC);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    redir_en    = 1'b0;
    mem_q.delete();
    exp_q.delete();
    pc_next     = 32'h0;
    currentPC   = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted IF/ID transfer must match the oldest
  // surviving grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pop", 64'(if_pc), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", 64'(if_pc), 64'(e.pc));
          check("sb_instr", 64'(if_instr), 64'(e.instr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        found;
    logic [31:0] first_pc;
    logic [31:0] stream_pc [4];
    stream_pc = '{32'h0, 32'h4, 32'h8, 32'hC};

    rst = 1'b1; currentPC = '0; redirect = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = '0; id_ready = 0; gnt_en = 0; rdy_en = 0; redir_en = 0;
    redir_target = '0; pc_next = '0;
    #3;
    check("rst_req",    64'(imem_req), 64'h0);
    check("rst_valid",  64'(if_valid), 64'h0);
    check("rst_pc",     64'(if_pc),    64'h0);
    check("rst_instr",  64'(if_instr), 64'h0);
    check("rst_pcw_lo", 64'(PCWrite),  64'h0);
    redirect = 1'b1; #1;
    check("rst_pcw_redir", 64'(PCWrite), 64'h1);
    redirect = 1'b0;
    do_reset();
    #1;
    check("post_rst_req",   64'(imem_req), 64'h1);
    check("post_rst_valid", 64'(if_valid), 64'h0);

    // Streaming with a 1-cycle memory.
    gnt_en = 1; rdy_en = 1; lat = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("stream_pcw", 64'(s_pcw), 64'h1);
      if (i < 2) check("stream_valid_lat", 64'(s_valid), 64'h0);
      else if (i < 6) begin
        check("stream_valid", 64'(s_valid), 64'h1);
        check("stream_pc", 64'(s_pc), 64'(stream_pc[i-2]));
      end
    end

    // Backpressure: queue fills to 4, PC holds at 16, then drains in order.
    do_reset();
    gnt_en = 1; rdy_en = 0; lat = 1; grants = 0;
    for (int i = 0; i < 8; i++) step();
    check("bp_grants", 64'(grants), 64'd4);
    check("bp_req_low", 64'(s_req), 64'h0);
    check("bp_pcw_low", 64'(s_pcw), 64'h0);
    check("bp_pc_hold", 64'(currentPC), 64'h10);
    rdy_en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_drain_valid", 64'(s_valid), 64'h1);
      check("bp_drain_pc", 64'(s_pc), 64'(stream_pc[i]));
    end

    // Redirect with two fetches in flight (3-cycle memory).
    do_reset();
    pc_next = 32'h8; lat = 3; gnt_en = 1; rdy_en = 1;
    step(); step();
    gnt_en = 0; redir_en = 1; redir_target = 32'h100;
    step();
    check("redir_req_low", 64'(s_req), 64'h0);
    check("redir_pcw", 64'(s_pcw), 64'h1);
    redir_en = 0; gnt_en = 1; found = 0; first_pc = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_valid && !found) begin found = 1; first_pc = s_pc; end
    end
    check("redir_found", 64'(found), 64'h1);
    check("redir_first_pc", 64'(first_pc), 64'h100);
    check("redir_drop_zero", 64'(dut.drop_cnt), 64'h0);

    // Redirect in the same cycle as a response.
    do_reset();
    lat = 1; gnt_en = 1; rdy_en = 1;
    step();
    redir_en = 1; redir_target = 32'h200;
    step();
    check("same_req_low", 64'(s_req), 64'h0);
    check("same_pcw", 64'(s_pcw), 64'h1);
    check("same_valid_low", 64'(s_valid), 64'h0);
    redir_en = 0; found = 0; first_pc = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_valid && !found) begin found = 1; first_pc = s_pc; end
    end
    check("same_first_pc", 64'(first_pc), 64'h200);
    check("same_drop_zero", 64'(dut.drop_cnt), 64'h0);

    // Back-to-back redirects with stale responses straddling them.
    do_reset();
    lat = 4; gnt_en = 1; rdy_en = 1;
    step(); step();
    redir_en = 1; redir_target = 32'h300; step();
    redir_en = 0; step();
    redir_en = 1; redir_target = 32'h400; step();
    redir_en = 0; found = 0; first_pc = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_valid && !found) begin found = 1; first_pc = s_pc; end
    end
    check("b2b_first_pc", 64'(first_pc), 64'h400);
    check("b2b_drop_zero", 64'(dut.drop_cnt), 64'h0);

    // Grant stall: request held, PC frozen.
    do_reset();
    lat = 1; gnt_en = 0; rdy_en = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req", 64'(s_req), 64'h1);
      check("stall_pcw", 64'(s_pcw), 64'h0);
      check("stall_addr", 64'(s_addr), 64'h0);
    end
    gnt_en = 1;
    step();
    check("stall_release_pcw", 64'(s_pcw), 64'h1);

    // Asynchronous reset with three entries buffered.
    do_reset();
    lat = 1; gnt_en = 1; rdy_en = 0;
    step(); step(); step();
    gnt_en = 0;
    step(); step();
    check("ar_valid_before", 64'(if_valid), 64'h1);
    check("ar_count_before", 64'(dut.u_queue.count), 64'h3);
    rst = 1'b1;
    #1;
    check("ar_valid_fall", 64'(if_valid), 64'h0);
    check("ar_req_low", 64'(imem_req), 64'h0);
    check("ar_alloc_ptr", 64'(dut.u_queue.alloc_ptr), 64'h0);
    check("ar_fill_ptr", 64'(dut.u_queue.fill_ptr), 64'h0);
    check("ar_rd_ptr", 64'(dut.u_queue.rd_ptr), 64'h0);
    do_reset();
    #1;
    check("ar_req_after", 64'(imem_req), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
